sweep_acq_sequencer: RTL and testbench
======================================

SWEEP_ACQ_SEQUENCER -- requirements
Module: sweep_acq_sequencer

Interface
REQ-001 Parameters SHALL be: DAC_WIDTH, default 10, DAC code width; CNT_WIDTH, default 16, package counter width; DATA_WIDTH, default 16, data word width (DATA_WIDTH > DAC_WIDTH); HEADER_TAG, default 6'h38, header tag of width DATA_WIDTH-DAC_WIDTH.
REQ-002 Ports SHALL be (name direction width meaning):
Clk  in  1  sole clock, rising edge
reset_n  in  1  asynchronous reset, active-low
SweepStart  in  1  one-cycle start pulse, honoured only in IDLE
SweepStop  in  1  one-cycle abort pulse
DacSelect  in  2  swept DAC: 0/1/2 = DAC0/1/2; 3 = all three together
StartDac, EndDac, DacStep  in  DAC_WIDTH each  sweep bounds and step
MaxPackageNumber  in  CNT_WIDTH  packages per sweep point
ParallelData_en  in  1  one pulse per acquired package
MicrorocConfigDone  in  1  slow-control load finished pulse
SweepAcqFifoData  in  DATA_WIDTH  FIFO read data, valid 1 cycle after rden
SweepAcqFifoEmpty  in  1  FIFO empty flag
OutDac0, OutDac1, OutDac2  out  DAC_WIDTH each  DAC codes to slow control
LoadScParameter  out  1  one-cycle slow-control load request
SingleAcqStart  out  1  acquisition enable level
SweepAcqFifoData_rden  out  1  FIFO read strobe
SweepAcqData  out  DATA_WIDTH  output word
SweepAcqData_en  out  1  output word valid
OneDacDone  out  1  one-cycle pulse per completed point
AcqDone  out  1  one-cycle pulse at sweep end
Busy  out  1  high in every state except IDLE

Function
REQ-003 Inputs StartDac, EndDac, DacStep, DacSelect, MaxPackageNumber SHALL be latched on accepted SweepStart; later changes SHALL not affect the running sweep.
REQ-004 DacStep = 0 SHALL be treated as 1; MaxPackageNumber = 0 SHALL be treated as 1.
REQ-005 Direction SHALL be up when StartDac <= EndDac, else down; StartDac = EndDac SHALL give exactly one point.
REQ-006 Next code SHALL be computed in DAC_WIDTH+1 bits; the sweep SHALL end when the next code passes EndDac or leaves 0..2^DAC_WIDTH-1 (no wrap-around); EndDac is swept only if reached exactly.
REQ-007 States SHALL be IDLE, LOAD, WAIT_CFG, HEADER, ACQ, DRAIN, NEXT, DONE.
REQ-008 IDLE->LOAD on SweepStart; LOAD drives current code onto the selected OutDac(s), pulses LoadScParameter one cycle, ->WAIT_CFG.
REQ-009 WAIT_CFG->HEADER on MicrorocConfigDone; HEADER emits one word {HEADER_TAG, current code} with SweepAcqData_en for one cycle, ->ACQ.
REQ-010 ACQ SHALL hold SingleAcqStart high and count ParallelData_en pulses from 0; when count reaches MaxPackageNumber SingleAcqStart SHALL drop on the next cycle and state ->DRAIN.
REQ-011 In ACQ and DRAIN, rden SHALL equal !SweepAcqFifoEmpty; SweepAcqData_en SHALL assert exactly one cycle after each rden with SweepAcqData = SweepAcqFifoData.
REQ-012 DRAIN->NEXT when FIFO empty and no read in flight; NEXT pulses OneDacDone, steps the code, ->LOAD or, if sweep ended, ->DONE.
REQ-013 DONE SHALL pulse AcqDone one cycle and ->IDLE; OutDac values SHALL hold last code.
REQ-014 Unselected OutDac outputs SHALL retain their prior values throughout.
REQ-015 SweepStop in LOAD/WAIT_CFG/HEADER/ACQ SHALL drop SingleAcqStart next cycle, ->DRAIN, then ->DONE without OneDacDone; in IDLE/DONE it SHALL be ignored.
REQ-016 SweepStart outside IDLE SHALL be ignored; ParallelData_en and SweepStop in the same cycle: stop SHALL win.
REQ-017 Header word and FIFO word SHALL never collide: HEADER state SHALL not read the FIFO.

Reset
REQ-018 On reset_n low all state SHALL clear asynchronously: state IDLE, OutDac0/1/2 = 0, all strobes, SingleAcqStart, Busy, SweepAcqData_en = 0, SweepAcqData = 0, counters = 0.
REQ-019 Reset mid-sweep SHALL abandon the sweep with no AcqDone; after release the block SHALL wait for a new SweepStart.

Verification
REQ-020 Start=100, End=102, Step=1, Sel=0, Max=2, FIFO supplies 2 words/point -> 3 LoadScParameter, headers 0xE064/0xE065/0xE066, 6 data words, 3 OneDacDone, 1 AcqDone.
REQ-021 Start=10, End=0, Step=4, Sel=3 -> points 10,6,2 on all three OutDac; no 0 point; AcqDone after third OneDacDone.
REQ-022 Start=1020, End=1023, Step=5 -> single point 1020, no wrap to low codes.
REQ-023 SweepStop during ACQ with 3 words in FIFO -> SingleAcqStart low next cycle, 3 words drained, AcqDone, no OneDacDone for that point.
REQ-024 reset_n pulsed low in WAIT_CFG -> all outputs 0 immediately; subsequent SweepStart runs full sweep normally.
REQ-025 Step=0, Max=0, Start=End=5 -> one point, one package accepted, one OneDacDone, AcqDone.

Source files
------------

// File: rtl/sweep_acq_sequencer.sv
// Sweeps a DAC code from StartDac towards EndDac, loads each point into slow control,
// emits a header word, acquires a set number of packages and drains the acquisition FIFO.
module sweep_acq_sequencer #(
   parameter int DAC_WIDTH  = 10,
   parameter int CNT_WIDTH  = 16,
   parameter int DATA_WIDTH = 16,
   parameter logic [DATA_WIDTH-DAC_WIDTH-1:0] HEADER_TAG = 6'h38
) (
   input  logic                  Clk,
   input  logic                  reset_n,
   input  logic                  SweepStart,
   input  logic                  SweepStop,
   input  logic [1:0]            DacSelect,
   input  logic [DAC_WIDTH-1:0]  StartDac,
   input  logic [DAC_WIDTH-1:0]  EndDac,
   input  logic [DAC_WIDTH-1:0]  DacStep,
   input  logic [CNT_WIDTH-1:0]  MaxPackageNumber,
   input  logic                  ParallelData_en,
   input  logic                  MicrorocConfigDone,
   input  logic [DATA_WIDTH-1:0] SweepAcqFifoData,
   input  logic                  SweepAcqFifoEmpty,
   output logic [DAC_WIDTH-1:0]  OutDac0,
   output logic [DAC_WIDTH-1:0]  OutDac1,
   output logic [DAC_WIDTH-1:0]  OutDac2,
   output logic                  LoadScParameter,
   output logic                  SingleAcqStart,
   output logic                  SweepAcqFifoData_rden,
   output logic [DATA_WIDTH-1:0] SweepAcqData,
   output logic                  SweepAcqData_en,
   output logic                  OneDacDone,
   output logic                  AcqDone,
   output logic                  Busy
);

   typedef enum logic [2:0] {IDLE, LOAD, WAIT_CFG, HEADER, ACQ, DRAIN, NEXT, DONE} state_t;

   state_t               r_state, w_state_nxt;
   logic [DAC_WIDTH-1:0] r_code, r_end, r_step;
   logic [DAC_WIDTH-1:0] r_dac0, r_dac1, r_dac2;
   logic [1:0]           r_sel;
   logic [CNT_WIDTH-1:0] r_max, r_cnt;
   logic                 r_up, r_stopped, r_rd_pend;

   logic [DAC_WIDTH:0]   w_next_code;
   logic                 w_sweep_end, w_stop_hit, w_pkt_last, w_rden, w_load_en;
   logic [DAC_WIDTH-1:0] w_load_code;
   logic [1:0]           w_load_sel;

   // One extra bit catches both overflow past the top code and borrow below zero
   always_comb begin
      w_next_code = r_up ? ({1'b0, r_code} + {1'b0, r_step})
                         : ({1'b0, r_code} - {1'b0, r_step});
      if (w_next_code[DAC_WIDTH])
         w_sweep_end = 1'b1;
      else if (r_up)
         w_sweep_end = (w_next_code[DAC_WIDTH-1:0] > r_end);
      else
         w_sweep_end = (w_next_code[DAC_WIDTH-1:0] < r_end);
   end

   always_comb begin
      w_stop_hit = SweepStop && (r_state == LOAD || r_state == WAIT_CFG ||
                                 r_state == HEADER || r_state == ACQ);
      w_pkt_last = ParallelData_en && ((r_cnt + CNT_WIDTH'(1)) == r_max);
      w_rden     = (r_state == ACQ || r_state == DRAIN) && !SweepAcqFifoEmpty;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:     if (SweepStart) w_state_nxt = LOAD;
         LOAD:     w_state_nxt = w_stop_hit ? DRAIN : WAIT_CFG;
         WAIT_CFG: if (w_stop_hit) w_state_nxt = DRAIN;
                   else if (MicrorocConfigDone) w_state_nxt = HEADER;
         HEADER:   w_state_nxt = w_stop_hit ? DRAIN : ACQ;
         ACQ:      if (w_stop_hit || w_pkt_last) w_state_nxt = DRAIN;
         DRAIN:    if (SweepAcqFifoEmpty && !r_rd_pend)
                      w_state_nxt = r_stopped ? DONE : NEXT;
         NEXT:     w_state_nxt = w_sweep_end ? DONE : LOAD;
         DONE:     w_state_nxt = IDLE;
         default:  w_state_nxt = IDLE;
      endcase
   end

   // DAC registers update on entry to LOAD so the code is stable while the load is requested
   always_comb begin
      w_load_en   = (w_state_nxt == LOAD);
      w_load_code = (r_state == IDLE) ? StartDac : w_next_code[DAC_WIDTH-1:0];
      w_load_sel  = (r_state == IDLE) ? DacSelect : r_sel;
   end

   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= IDLE;
         r_code    <= '0;
         r_end     <= '0;
         r_step    <= '0;
         r_sel     <= '0;
         r_max     <= '0;
         r_cnt     <= '0;
         r_up      <= 1'b0;
         r_stopped <= 1'b0;
         r_rd_pend <= 1'b0;
         r_dac0    <= '0;
         r_dac1    <= '0;
         r_dac2    <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_rd_pend <= w_rden;
         if (r_state == IDLE && SweepStart) begin
            r_code    <= StartDac;
            r_end     <= EndDac;
            r_step    <= (DacStep == '0) ? DAC_WIDTH'(1) : DacStep;
            r_sel     <= DacSelect;
            r_max     <= (MaxPackageNumber == '0) ? CNT_WIDTH'(1) : MaxPackageNumber;
            r_up      <= (StartDac <= EndDac);
            r_stopped <= 1'b0;
         end
         if (r_state == NEXT && !w_sweep_end)
            r_code <= w_next_code[DAC_WIDTH-1:0];
         if (r_state == LOAD)
            r_cnt <= '0;
         else if (r_state == ACQ && ParallelData_en && !SweepStop)
            r_cnt <= r_cnt + CNT_WIDTH'(1);
         if (w_stop_hit)
            r_stopped <= 1'b1;
         if (w_load_en) begin
            if (w_load_sel == 2'd0 || w_load_sel == 2'd3) r_dac0 <= w_load_code;
            if (w_load_sel == 2'd1 || w_load_sel == 2'd3) r_dac1 <= w_load_code;
            if (w_load_sel == 2'd2 || w_load_sel == 2'd3) r_dac2 <= w_load_code;
         end
      end
   end

   // Reads only happen in ACQ/DRAIN, so a pending FIFO word never overlaps the header
   always_comb begin
      if (r_state == HEADER)
         SweepAcqData = {HEADER_TAG, r_code};
      else if (r_rd_pend)
         SweepAcqData = SweepAcqFifoData;
      else
         SweepAcqData = '0;
   end

   assign SweepAcqData_en       = (r_state == HEADER) || r_rd_pend;
   assign SweepAcqFifoData_rden = w_rden;
   assign LoadScParameter       = (r_state == LOAD);
   assign SingleAcqStart        = (r_state == ACQ);
   assign OneDacDone            = (r_state == NEXT);
   assign AcqDone               = (r_state == DONE);
   assign Busy                  = (r_state != IDLE);
   assign OutDac0               = r_dac0;
   assign OutDac1               = r_dac1;
   assign OutDac2               = r_dac2;

endmodule

// File: tb/tb_sweep_acq_sequencer.sv
// Bench for sweep_acq_sequencer: slow-control, acquisition and FIFO responders plus a
// point-list reference model that predicts DAC snapshots and the output word stream.
module tb_sweep_acq_sequencer;

   logic        Clk = 1'b0;
   logic        reset_n;
   logic        SweepStart, SweepStop;
   logic [1:0]  DacSelect;
   logic [9:0]  StartDac, EndDac, DacStep;
   logic [15:0] MaxPackageNumber;
   logic        ParallelData_en;
   logic        MicrorocConfigDone;
   logic [15:0] SweepAcqFifoData;
   logic        SweepAcqFifoEmpty;
   logic [9:0]  OutDac0, OutDac1, OutDac2;
   logic        LoadScParameter, SingleAcqStart, SweepAcqFifoData_rden;
   logic [15:0] SweepAcqData;
   logic        SweepAcqData_en, OneDacDone, AcqDone, Busy;

   int vectors = 0;
   int miscompares = 0;

   int cfg_en = 1;
   int acq_en = 1;
   int pde_req = 0;
   int wpp = 1;

   logic [15:0] pool[$];
   int          pool_idx = 0;
   logic [15:0] fifo_q[$];

   logic [15:0] got_words[$];
   int          got_d0[$], got_d1[$], got_d2[$];
   int          n_one = 0;
   int          n_acq = 0;
   int          mdac[3];

   sweep_acq_sequencer dut (
      .Clk                   (Clk),
      .reset_n               (reset_n),
      .SweepStart            (SweepStart),
      .SweepStop             (SweepStop),
      .DacSelect             (DacSelect),
      .StartDac              (StartDac),
      .EndDac                (EndDac),
      .DacStep               (DacStep),
      .MaxPackageNumber      (MaxPackageNumber),
      .ParallelData_en       (ParallelData_en),
      .MicrorocConfigDone    (MicrorocConfigDone),
      .SweepAcqFifoData      (SweepAcqFifoData),
      .SweepAcqFifoEmpty     (SweepAcqFifoEmpty),
      .OutDac0               (OutDac0),
      .OutDac1               (OutDac1),
      .OutDac2               (OutDac2),
      .LoadScParameter       (LoadScParameter),
      .SingleAcqStart        (SingleAcqStart),
      .SweepAcqFifoData_rden (SweepAcqFifoData_rden),
      .SweepAcqData          (SweepAcqData),
      .SweepAcqData_en       (SweepAcqData_en),
      .OneDacDone            (OneDacDone),
      .AcqDone               (AcqDone),
      .Busy                  (Busy)
   );

   always #5 Clk = ~Clk;

   // FIFO model: data valid the cycle after a read; each package pushes wpp pool words
   initial begin
      SweepAcqFifoData  = 16'd0;
      SweepAcqFifoEmpty = 1'b1;
      forever begin
         @(posedge Clk);
         if (!reset_n) begin
            fifo_q.delete();
            SweepAcqFifoData  <= 16'd0;
            SweepAcqFifoEmpty <= 1'b1;
         end else begin
            if (SweepAcqFifoData_rden && fifo_q.size() > 0)
               SweepAcqFifoData <= fifo_q.pop_front();
            if (ParallelData_en)
               for (int i = 0; i < wpp; i++) begin
                  fifo_q.push_back(pool[pool_idx]);
                  pool_idx++;
               end
            SweepAcqFifoEmpty <= (fifo_q.size() == 0);
         end
      end
   end

   initial begin
      MicrorocConfigDone = 1'b0;
      forever begin
         @(negedge Clk);
         if (LoadScParameter && cfg_en != 0) begin
            repeat ($urandom_range(1, 4)) @(negedge Clk);
            MicrorocConfigDone = 1'b1;
            @(negedge Clk);
            MicrorocConfigDone = 1'b0;
         end
      end
   end

   initial begin
      ParallelData_en = 1'b0;
      forever begin
         @(negedge Clk);
         if (acq_en != 0)
            ParallelData_en = SingleAcqStart && ($urandom_range(0, 2) == 0);
         else
            ParallelData_en = (pde_req != 0);
      end
   end

   initial begin
      forever begin
         @(negedge Clk);
         if (reset_n) begin
            if (SweepAcqData_en) got_words.push_back(SweepAcqData);
            if (LoadScParameter) begin
               got_d0.push_back(int'(OutDac0));
               got_d1.push_back(int'(OutDac1));
               got_d2.push_back(int'(OutDac2));
            end
            if (OneDacDone) n_one++;
            if (AcqDone) n_acq++;
         end
      end
   end

   task automatic recover;
      reset_n = 1'b0;
      repeat (2) @(negedge Clk);
      reset_n = 1'b1;
      mdac[0] = 0; mdac[1] = 0; mdac[2] = 0;
      @(negedge Clk);
   endtask

   task automatic run_sweep(input int s_start, input int s_end, input int s_step,
                            input int s_sel, input int s_max, input int s_wpp,
                            input string tag);
      int pts[$];
      logic [15:0] ew[$];
      int e0[$], e1[$], e2[$];
      int ptr, stp, mx, c, nx, bw, bd, b1, ba, to;
      logic [9:0] pc;
      stp = (s_step == 0) ? 1 : s_step;
      mx  = (s_max == 0) ? 1 : s_max;
      c   = s_start;
      forever begin
         pts.push_back(c);
         nx = (s_start <= s_end) ? c + stp : c - stp;
         if (nx < 0 || nx > 1023 || (s_start <= s_end && nx > s_end) ||
             (s_start > s_end && nx < s_end)) break;
         c = nx;
      end
      ptr = pool_idx;
      foreach (pts[i]) begin
         if (s_sel == 3) begin
            mdac[0] = pts[i]; mdac[1] = pts[i]; mdac[2] = pts[i];
         end else
            mdac[s_sel] = pts[i];
         e0.push_back(mdac[0]); e1.push_back(mdac[1]); e2.push_back(mdac[2]);
         pc = 10'(pts[i]);
         ew.push_back({6'h38, pc});
         for (int k = 0; k < mx * s_wpp; k++) begin
            ew.push_back(pool[ptr]);
            ptr++;
         end
      end
      wpp = s_wpp;
      bw = got_words.size(); bd = got_d0.size(); b1 = n_one; ba = n_acq;
      @(negedge Clk);
      StartDac = 10'(s_start); EndDac = 10'(s_end); DacStep = 10'(s_step);
      DacSelect = 2'(s_sel); MaxPackageNumber = 16'(s_max);
      SweepStart = 1'b1;
      @(negedge Clk);
      SweepStart = 1'b0;
      StartDac = 10'($urandom); EndDac = 10'($urandom); DacStep = 10'($urandom);
      DacSelect = 2'($urandom); MaxPackageNumber = 16'($urandom_range(0, 9));
      repeat (2) @(negedge Clk);
      SweepStart = 1'b1;
      @(negedge Clk);
      SweepStart = 1'b0;
      to = 0;
      while (n_acq == ba && to < 8000) begin
         @(negedge Clk);
         to++;
      end
      vectors++;
      if (n_acq == ba) begin
         miscompares++;
         $display("FAIL %s_timeout AcqDone not seen within %0d cycles", tag, to);
         recover();
      end
      repeat (3) @(negedge Clk);
      vectors++;
      if (n_acq - ba !== 1) begin
         miscompares++;
         $display("FAIL %s_acqdone got %0d pulses want 1", tag, n_acq - ba);
      end
      vectors++;
      if (n_one - b1 !== pts.size()) begin
         miscompares++;
         $display("FAIL %s_onedacdone got %0d want %0d", tag, n_one - b1, pts.size());
      end
      vectors++;
      if (got_d0.size() - bd !== pts.size()) begin
         miscompares++;
         $display("FAIL %s_loads got %0d want %0d", tag, got_d0.size() - bd, pts.size());
      end
      for (int i = 0; i < e0.size() && bd + i < got_d0.size(); i++) begin
         vectors++;
         if (got_d0[bd+i] !== e0[i] || got_d1[bd+i] !== e1[i] || got_d2[bd+i] !== e2[i]) begin
            miscompares++;
            $display("FAIL %s_outdac[%0d] got %0d/%0d/%0d want %0d/%0d/%0d", tag, i,
                     got_d0[bd+i], got_d1[bd+i], got_d2[bd+i], e0[i], e1[i], e2[i]);
         end
      end
      vectors++;
      if (got_words.size() - bw !== ew.size()) begin
         miscompares++;
         $display("FAIL %s_wordcount got %0d want %0d", tag, got_words.size() - bw, ew.size());
      end
      for (int i = 0; i < ew.size() && bw + i < got_words.size(); i++) begin
         vectors++;
         if (got_words[bw+i] !== ew[i]) begin
            miscompares++;
            $display("FAIL %s_word[%0d] got %04h want %04h", tag, i, got_words[bw+i], ew[i]);
         end
      end
      vectors++;
      if (Busy !== 1'b0) begin
         miscompares++;
         $display("FAIL %s_busy_after got %b want 0", tag, Busy);
      end
   endtask

   task automatic test_reset;
      reset_n = 1'b1;
      #3 reset_n = 1'b0;
      #1;
      vectors++;
      if ({OutDac0, OutDac1, OutDac2} !== 30'd0) begin
         miscompares++;
         $display("FAIL reset_outdac got %h want 0", {OutDac0, OutDac1, OutDac2});
      end
      repeat (2) @(negedge Clk);
      vectors++;
      if ({LoadScParameter, SingleAcqStart, SweepAcqFifoData_rden, SweepAcqData_en,
           OneDacDone, AcqDone, Busy} !== 7'd0) begin
         miscompares++;
         $display("FAIL reset_strobes got %b want 0000000", {LoadScParameter, SingleAcqStart,
                  SweepAcqFifoData_rden, SweepAcqData_en, OneDacDone, AcqDone, Busy});
      end
      vectors++;
      if (SweepAcqData !== 16'd0) begin
         miscompares++;
         $display("FAIL reset_data got %04h want 0000", SweepAcqData);
      end
      reset_n = 1'b1;
      repeat (2) @(negedge Clk);
   endtask

   task automatic test_basic_sweep;
      run_sweep(100, 102, 1, 0, 2, 1, "up3");
   endtask

   task automatic test_down_all;
      run_sweep(10, 0, 4, 3, 1, 2, "down_all");
   endtask

   task automatic test_no_wrap;
      run_sweep(1020, 1023, 5, 2, 1, 1, "nowrap");
   endtask

   task automatic test_zero_step_max;
      run_sweep(5, 5, 0, 1, 0, 2, "zero");
   endtask

   task automatic test_stop;
      int ptr, to, bw, bd, b1, ba;
      acq_en = 0; wpp = 3;
      ptr = pool_idx;
      bw = got_words.size(); bd = got_d0.size(); b1 = n_one; ba = n_acq;
      @(negedge Clk);
      StartDac = 10'd200; EndDac = 10'd210; DacStep = 10'd1; DacSelect = 2'd1;
      MaxPackageNumber = 16'd5; SweepStart = 1'b1;
      @(negedge Clk);
      SweepStart = 1'b0;
      to = 0;
      while (!SingleAcqStart && to < 200) begin
         @(negedge Clk);
         to++;
      end
      vectors++;
      if (SingleAcqStart !== 1'b1) begin
         miscompares++;
         $display("FAIL stop_reach_acq got %b want 1", SingleAcqStart);
      end
      @(posedge Clk); #1;
      pde_req = 1; SweepStop = 1'b1;
      @(posedge Clk); #1;
      pde_req = 0; SweepStop = 1'b0;
      @(negedge Clk);
      vectors++;
      if ({SingleAcqStart, Busy} !== 2'b01) begin
         miscompares++;
         $display("FAIL stop_acqstart_drop got acq=%b busy=%b want acq=0 busy=1",
                  SingleAcqStart, Busy);
      end
      to = 0;
      while (n_acq == ba && to < 500) begin
         @(negedge Clk);
         to++;
      end
      repeat (3) @(negedge Clk);
      vectors++;
      if (n_acq - ba !== 1) begin
         miscompares++;
         $display("FAIL stop_acqdone got %0d want 1", n_acq - ba);
      end
      vectors++;
      if (n_one - b1 !== 0) begin
         miscompares++;
         $display("FAIL stop_onedacdone got %0d want 0", n_one - b1);
      end
      vectors++;
      if (got_d0.size() - bd !== 1 || got_d1[bd] !== 200) begin
         miscompares++;
         $display("FAIL stop_load got %0d loads dac1=%0d want 1 load dac1=200",
                  got_d0.size() - bd, got_d1[bd]);
      end
      vectors++;
      if (got_words.size() - bw !== 4) begin
         miscompares++;
         $display("FAIL stop_wordcount got %0d want 4", got_words.size() - bw);
      end else begin
         vectors++;
         if (got_words[bw] !== 16'hE0C8) begin
            miscompares++;
            $display("FAIL stop_header got %04h want e0c8", got_words[bw]);
         end
         for (int i = 0; i < 3; i++) begin
            vectors++;
            if (got_words[bw+1+i] !== pool[ptr+i]) begin
               miscompares++;
               $display("FAIL stop_word[%0d] got %04h want %04h", i, got_words[bw+1+i],
                        pool[ptr+i]);
            end
         end
      end
      mdac[1] = 200;
      acq_en = 1;
   endtask

   task automatic test_reset_mid;
      int to, ba;
      cfg_en = 0;
      ba = n_acq;
      @(negedge Clk);
      StartDac = 10'd300; EndDac = 10'd303; DacStep = 10'd1; DacSelect = 2'd0;
      MaxPackageNumber = 16'd1; SweepStart = 1'b1;
      @(negedge Clk);
      SweepStart = 1'b0;
      to = 0;
      while (!LoadScParameter && to < 50) begin
         @(negedge Clk);
         to++;
      end
      repeat (2) @(negedge Clk);
      vectors++;
      if ({Busy, OutDac0} !== {1'b1, 10'd300}) begin
         miscompares++;
         $display("FAIL rstmid_waitcfg got busy=%b dac0=%0d want busy=1 dac0=300", Busy, OutDac0);
      end
      #2 reset_n = 1'b0;
      #1;
      vectors++;
      if ({OutDac0, OutDac1, OutDac2, Busy, LoadScParameter, SingleAcqStart,
           SweepAcqData_en, SweepAcqData} !== 50'd0) begin
         miscompares++;
         $display("FAIL rstmid_async dac=%0d/%0d/%0d busy=%b data=%04h want all 0",
                  OutDac0, OutDac1, OutDac2, Busy, SweepAcqData);
      end
      repeat (2) @(negedge Clk);
      reset_n = 1'b1;
      cfg_en = 1;
      mdac[0] = 0; mdac[1] = 0; mdac[2] = 0;
      repeat (6) @(negedge Clk);
      vectors++;
      if ({Busy, n_acq - ba} !== {1'b0, 32'd0}) begin
         miscompares++;
         $display("FAIL rstmid_abandon got busy=%b acqdone=%0d want busy=0 acqdone=0",
                  Busy, n_acq - ba);
      end
      run_sweep(300, 302, 1, 0, 1, 2, "after_rst");
   endtask

   task automatic test_random;
      int s, e, span, st, sel, mx, w;
      for (int t = 0; t < 6; t++) begin
         s    = (t == 5) ? $urandom_range(1000, 1023) : $urandom_range(0, 1023);
         span = $urandom_range(0, 50);
         e    = ($urandom_range(0, 1) == 1) ? s + span : s - span;
         if (e > 1023) e = 1023;
         if (e < 0) e = 0;
         st  = $urandom_range(0, 12);
         sel = $urandom_range(0, 3);
         mx  = $urandom_range(0, 3);
         w   = $urandom_range(0, 3);
         run_sweep(s, e, st, sel, mx, w, "rand");
      end
   endtask

   initial begin
      reset_n = 1'b1;
      SweepStart = 1'b0; SweepStop = 1'b0;
      DacSelect = 2'd0; StartDac = 10'd0; EndDac = 10'd0; DacStep = 10'd0;
      MaxPackageNumber = 16'd0;
      mdac[0] = 0; mdac[1] = 0; mdac[2] = 0;
      for (int i = 0; i < 8000; i++) pool.push_back(16'($urandom));
      test_reset();
      test_basic_sweep();
      test_down_all();
      test_no_wrap();
      test_zero_step_max();
      test_stop();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
